// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the slow-access stall controller.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      RELEASE  = 2'd2,
      DONE     = 2'd3
   } stall_state_t;

   // Read data returned on a timed-out access; sliced down to the bus width by users (max 256 bits).
   localparam int RDATA_ERR_MAX_W = 256;
   localparam logic [RDATA_ERR_MAX_W-1:0] RDATA_ERR_VALUE = {RDATA_ERR_MAX_W{1'b1}};

endpackage

// File: rtl/stall_ctrl.sv
// Freezes the CPU clock during slow slave accesses, runs the req/ack exchange,
// and releases the CPU with a one-cycle handshake; includes timeout and stall counter.
module stall_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 32
) (
   input  logic              MASTER_CLK,
   input  logic              RST_N,
   input  logic              MEM_REQ,
   input  logic              MEM_WE,
   input  logic              SLAVE_ACK,
   input  logic              SLAVE_ERR,
   input  logic [DATA_W-1:0] SLAVE_RDATA,
   output logic              SLAVE_REQ,
   output logic              SLAVE_WE,
   output logic              WAIT_SIGNAL,
   output logic              HANDSHAKE,
   output logic [DATA_W-1:0] RDATA_OUT,
   output logic              ACCESS_ERR,
   output logic [CNT_W-1:0]  STALL_CYCLES
);

   localparam logic [15:0]       TIMEOUT_LOAD  = 16'(TIMEOUT_CYCLES);
   localparam logic [15:0]       TIMEOUT_LAST  = 16'd1;
   localparam logic [15:0]       TIMEOUT_STEP  = 16'd1;
   localparam logic [CNT_W-1:0]  STALL_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  STALL_ONE     = CNT_W'(1);
   localparam logic [DATA_W-1:0] RDATA_TIMEOUT = RDATA_ERR_VALUE[DATA_W-1:0];

   stall_state_t      state_r;
   logic [15:0]       tmo_cnt_r;
   logic              slave_req_r;
   logic              slave_we_r;
   logic              wait_r;
   logic              handshake_r;
   logic [DATA_W-1:0] rdata_r;
   logic              access_err_r;
   logic [CNT_W-1:0]  stall_cnt_r;

   // Access sequencer: state, registered outputs, timeout and stall counters.
   always_ff @(posedge MASTER_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r      <= IDLE;
         tmo_cnt_r    <= 16'd0;
         slave_req_r  <= 1'b0;
         slave_we_r   <= 1'b0;
         wait_r       <= 1'b0;
         handshake_r  <= 1'b0;
         rdata_r      <= '0;
         access_err_r <= 1'b0;
         stall_cnt_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               slave_we_r <= MEM_WE;
               tmo_cnt_r  <= TIMEOUT_LOAD;
               if (MEM_REQ) begin
                  state_r     <= WAIT_ACK;
                  wait_r      <= 1'b1;
                  slave_req_r <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            WAIT_ACK: begin
               if (stall_cnt_r != STALL_MAX) begin
                  stall_cnt_r <= stall_cnt_r + STALL_ONE;
               end else begin
                  stall_cnt_r <= stall_cnt_r;
               end
               // An ack on the last counted cycle beats the timeout.
               if (SLAVE_ACK) begin
                  if (!slave_we_r) begin
                     rdata_r <= SLAVE_RDATA;
                  end else begin
                     rdata_r <= rdata_r;
                  end
                  if (SLAVE_ERR) begin
                     access_err_r <= 1'b1;
                  end else begin
                     access_err_r <= access_err_r;
                  end
                  state_r     <= RELEASE;
                  slave_req_r <= 1'b0;
                  handshake_r <= 1'b1;
               end else if (tmo_cnt_r <= TIMEOUT_LAST) begin
                  access_err_r <= 1'b1;
                  rdata_r      <= RDATA_TIMEOUT;
                  state_r      <= RELEASE;
                  slave_req_r  <= 1'b0;
                  handshake_r  <= 1'b1;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r - TIMEOUT_STEP;
               end
            end
            RELEASE: begin
               state_r     <= DONE;
               wait_r      <= 1'b0;
               handshake_r <= 1'b0;
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r     <= IDLE;
               slave_req_r <= 1'b0;
               wait_r      <= 1'b0;
               handshake_r <= 1'b0;
            end
         endcase
      end
   end

   assign SLAVE_REQ    = slave_req_r;
   assign SLAVE_WE     = slave_we_r;
   assign WAIT_SIGNAL  = wait_r;
   assign HANDSHAKE    = handshake_r;
   assign RDATA_OUT    = rdata_r;
   assign ACCESS_ERR   = access_err_r;
   assign STALL_CYCLES = stall_cnt_r;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed, table-driven bench for stall_ctrl (TIMEOUT_CYCLES=5, CNT_W=4).
module tb_stall_ctrl;

   logic        master_clk;
   logic        rst_n;
   logic        mem_req;
   logic        mem_we;
   logic        slave_ack;
   logic        slave_err;
   logic [31:0] slave_rdata;
   logic        slave_req;
   logic        slave_we;
   logic        wait_signal;
   logic        handshake;
   logic [31:0] rdata_out;
   logic        access_err;
   logic [3:0]  stall_cycles;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        req, we, ack, err;
      logic [31:0] rd;
      logic        w, h, r, s, e;
      logic [3:0]  st;
      logic [31:0] d;
   } vec_t;

   vec_t tbl[23];

   stall_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(5), .CNT_W(4)) dut (
      .MASTER_CLK   (master_clk),
      .RST_N        (rst_n),
      .MEM_REQ      (mem_req),
      .MEM_WE       (mem_we),
      .SLAVE_ACK    (slave_ack),
      .SLAVE_ERR    (slave_err),
      .SLAVE_RDATA  (slave_rdata),
      .SLAVE_REQ    (slave_req),
      .SLAVE_WE     (slave_we),
      .WAIT_SIGNAL  (wait_signal),
      .HANDSHAKE    (handshake),
      .RDATA_OUT    (rdata_out),
      .ACCESS_ERR   (access_err),
      .STALL_CYCLES (stall_cycles)
   );

   initial master_clk = 1'b0;
   always #5 master_clk = ~master_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench watchdog expired");
   end

   function automatic vec_t mk(logic req, logic we, logic ack, logic err, logic [31:0] rd,
                               logic w, logic h, logic r, logic s, logic e,
                               logic [3:0] st, logic [31:0] d);
      vec_t v;
      v.req = req; v.we = we; v.ack = ack; v.err = err; v.rd = rd;
      v.w = w; v.h = h; v.r = r; v.s = s; v.e = e; v.st = st; v.d = d;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {23'd0, wait_signal, handshake, slave_req, slave_we, access_err, stall_cycles, rdata_out};
   endfunction

   task automatic step();
      @(posedge master_clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge master_clk);
      rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      slave_ack = 1'b0; slave_err = 1'b0; slave_rdata = 32'd0;
      @(negedge master_clk);
      @(negedge master_clk);
      rst_n = 1'b1;
   endtask

   // Launch a read with no ack; returns in RELEASE with the number of stall cycles seen.
   task automatic no_ack_access(output int n, output bit released);
      @(negedge master_clk);
      mem_req = 1'b1; mem_we = 1'b0; slave_ack = 1'b0;
      step();
      mem_req = 1'b0;
      n = 0;
      released = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (handshake) begin
            released = 1'b1;
            break;
         end
         if (wait_signal) n++;
         step();
      end
   endtask

   initial begin
      int  n;
      bit  rel;

      tbl[0]  = mk(1,0,0,0,32'h0,        1,0,1,0,0, 4'd0,  32'h0);
      tbl[1]  = mk(1,0,0,0,32'h0,        1,0,1,0,0, 4'd1,  32'h0);
      tbl[2]  = mk(1,0,0,0,32'h0,        1,0,1,0,0, 4'd2,  32'h0);
      tbl[3]  = mk(1,0,1,0,32'hDEADBEEF, 1,1,0,0,0, 4'd3,  32'hDEADBEEF);
      tbl[4]  = mk(0,0,1,0,32'h12345678, 0,0,0,0,0, 4'd3,  32'hDEADBEEF);
      tbl[5]  = mk(0,0,0,0,32'h0,        0,0,0,0,0, 4'd3,  32'hDEADBEEF);
      tbl[6]  = mk(1,1,0,0,32'h0,        1,0,1,1,0, 4'd3,  32'hDEADBEEF);
      tbl[7]  = mk(0,0,1,0,32'hCAFEF00D, 1,1,0,1,0, 4'd4,  32'hDEADBEEF);
      tbl[8]  = mk(0,0,0,0,32'h0,        0,0,0,1,0, 4'd4,  32'hDEADBEEF);
      tbl[9]  = mk(0,0,0,0,32'h0,        0,0,0,1,0, 4'd4,  32'hDEADBEEF);
      tbl[10] = mk(0,0,0,0,32'h0,        0,0,0,0,0, 4'd4,  32'hDEADBEEF);
      tbl[11] = mk(1,0,0,0,32'h0,        1,0,1,0,0, 4'd4,  32'hDEADBEEF);
      tbl[12] = mk(0,0,0,0,32'h0,        1,0,1,0,0, 4'd5,  32'hDEADBEEF);
      tbl[13] = mk(0,0,0,0,32'h0,        1,0,1,0,0, 4'd6,  32'hDEADBEEF);
      tbl[14] = mk(0,0,0,0,32'h0,        1,0,1,0,0, 4'd7,  32'hDEADBEEF);
      tbl[15] = mk(0,0,0,0,32'h0,        1,0,1,0,0, 4'd8,  32'hDEADBEEF);
      tbl[16] = mk(0,0,1,0,32'hA5A55A5A, 1,1,0,0,0, 4'd9,  32'hA5A55A5A);
      tbl[17] = mk(0,0,0,0,32'h0,        0,0,0,0,0, 4'd9,  32'hA5A55A5A);
      tbl[18] = mk(0,0,0,0,32'h0,        0,0,0,0,0, 4'd9,  32'hA5A55A5A);
      tbl[19] = mk(1,0,0,0,32'h0,        1,0,1,0,0, 4'd9,  32'hA5A55A5A);
      tbl[20] = mk(0,0,1,1,32'h11112222, 1,1,0,0,1, 4'd10, 32'h11112222);
      tbl[21] = mk(0,0,0,1,32'h0,        0,0,0,0,1, 4'd10, 32'h11112222);
      tbl[22] = mk(0,0,0,0,32'h0,        0,0,0,0,1, 4'd10, 32'h11112222);

      rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      slave_ack = 1'b0; slave_err = 1'b0; slave_rdata = 32'd0;
      step();
      step();
      cmp("reset_state", outs(), 64'd0);
      @(negedge master_clk);
      rst_n = 1'b1;

      // Read (ack on 3rd wait cycle), write (fastest ack), ack on last timeout cycle, slave error.
      for (int i = 0; i < 23; i++) begin
         @(negedge master_clk);
         mem_req     = tbl[i].req;
         mem_we      = tbl[i].we;
         slave_ack   = tbl[i].ack;
         slave_err   = tbl[i].err;
         slave_rdata = tbl[i].rd;
         step();
         cmp($sformatf("vec%0d", i), outs(),
             {23'd0, tbl[i].w, tbl[i].h, tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].st, tbl[i].d});
      end

      // Timeout with no ack.
      do_reset();
      no_ack_access(n, rel);
      cmp("timeout_released", 64'(rel), 64'd1);
      cmp("timeout_wait_cycles", 64'(n), 64'd5);
      cmp("timeout_err", 64'(access_err), 64'd1);
      cmp("timeout_rdata", 64'(rdata_out), 64'hFFFFFFFF);
      cmp("timeout_stall", 64'(stall_cycles), 64'd5);
      step();
      cmp("timeout_cpu_free", {62'd0, wait_signal, handshake}, 64'd0);

      // Back-to-back with MEM_REQ held high.
      do_reset();
      @(negedge master_clk);
      mem_req = 1'b1; mem_we = 1'b0;
      step();
      @(negedge master_clk);
      slave_ack = 1'b1; slave_rdata = 32'h0BADF00D;
      step();
      cmp("b2b_release", {62'd0, handshake, slave_req}, 64'd2);
      @(negedge master_clk);
      slave_ack = 1'b0;
      step();
      cmp("b2b_done_no_restart", {62'd0, wait_signal, slave_req}, 64'd0);
      step();
      cmp("b2b_idle", {62'd0, wait_signal, slave_req}, 64'd0);
      step();
      cmp("b2b_second_start", {62'd0, wait_signal, slave_req}, 64'd3);
      cmp("b2b_first_data", 64'(rdata_out), 64'h0BADF00D);

      // Reset asserted mid-access.
      do_reset();
      @(negedge master_clk);
      mem_req = 1'b1;
      step();
      mem_req = 1'b0;
      step();
      step();
      cmp("pre_reset_busy", {60'd0, stall_cycles}, 64'd2);
      @(negedge master_clk);
      #2;
      rst_n = 1'b0;
      #1;
      cmp("async_reset_outs", outs(), 64'd0);
      @(negedge master_clk);
      rst_n = 1'b1;

      // Stall counter saturation: four timeouts give 20 stall cycles.
      for (int k = 1; k <= 4; k++) begin
         no_ack_access(n, rel);
         step();
         step();
         cmp($sformatf("sat_after_%0d", k), 64'(stall_cycles), (k * 5 > 15) ? 64'd15 : 64'(k * 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
